// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-command-side signal bundle of the round-robin APB request arbiter.
// The arbiter takes the slave modport; the requesters and the APB master take the master modport.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      err;
  logic                      transfer;
  logic                      pwrite_in;
  logic [ADDR_W-1:0]         paddr_in;
  logic [DATA_W-1:0]         pwdata_in;
  logic                      m_done;
  logic [DATA_W-1:0]         m_rdata;

  modport master (
    output req, req_write, req_addr, req_wdata, m_done, m_rdata,
    input  gnt, done, rdata, err, transfer, pwrite_in, paddr_in, pwdata_in
  );

  modport slave (
    input  req, req_write, req_addr, req_wdata, m_done, m_rdata,
    output gnt, done, rdata, err, transfer, pwrite_in, paddr_in, pwdata_in
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master between NUM_REQ requesters,
// with a watchdog that aborts transfers the master never completes.
module apb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input logic              pclk,
  input logic              presetn,
  apb_req_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [CNT_W-1:0]   WD_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [CNT_W-1:0]   wd_cnt;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic               transfer_q;
  logic               pwrite_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [DATA_W-1:0]  pwdata_q;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  // Scan from farthest to nearest so the slot closest after ptr wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (bus.req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      ptr        <= IDX_W'(NUM_REQ - 1);
      win_idx    <= '0;
      wd_cnt     <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      transfer_q <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= '0;
          if (pick_valid) begin
            state      <= XFER;
            win_idx    <= pick_idx;
            wd_cnt     <= '0;
            gnt_q      <= ONE_HOT0 << pick_idx;
            transfer_q <= 1'b1;
            pwrite_q   <= bus.req_write[pick_idx];
            paddr_q    <= bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
            pwdata_q   <= bus.req_wdata[pick_idx*DATA_W +: DATA_W];
          end
        end
        XFER: begin
          // A completion in the watchdog's last cycle still counts as success.
          if (bus.m_done || (wd_cnt == WD_LAST)) begin
            state      <= RESP;
            done_q     <= gnt_q;
            gnt_q      <= '0;
            transfer_q <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            err_q      <= ~bus.m_done;
            rdata_q    <= (bus.m_done && !pwrite_q) ? bus.m_rdata : '0;
          end
          wd_cnt <= wd_cnt + CNT_W'(1);
        end
        RESP: begin
          state  <= IDLE;
          done_q <= '0;
          ptr    <= win_idx;
          wd_cnt <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign bus.transfer  = transfer_q;
  assign bus.pwrite_in = pwrite_q;
  assign bus.paddr_in  = paddr_q;
  assign bus.pwdata_in = pwdata_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios followed by
// randomized transactions, checked against a transaction-level model.
module tb_apb_req_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic pclk = 1'b0;
  logic presetn;

  int checks = 0;
  int errors = 0;

  // Model state: last served requester and the values rdata/err must hold.
  int         ptr_m;
  logic [7:0] exp_rdata;
  logic       exp_err;

  apb_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rq, input logic [3:0] wr,
                               input logic [31:0] ad, input logic [31:0] wd);
    bus.req       = rq;
    bus.req_write = wr;
    bus.req_addr  = ad;
    bus.req_wdata = wd;
  endtask

  // Winner = first requesting slot after the last one served, wrapping around.
  function automatic int modelPick(input logic [3:0] rq);
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (rq[(ptr_m + i) % NUM_REQ]) return (ptr_m + i) % NUM_REQ;
    end
    return -1;
  endfunction

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  // dly = XFER cycle index at which m_done is sampled; dly >= TIMEOUT means never.
  task automatic runTxn(input logic [3:0] rq, input logic [3:0] wr, input logic [31:0] ad,
                        input logic [31:0] wd, input int dly, input logic [7:0] mrd,
                        input bit abuse);
    int         w;
    bit         to;
    logic       e_wr;
    logic [7:0] e_addr;
    logic [7:0] e_wdata;
    applyStimulus(rq, wr, ad, wd);
    bus.m_done  = 1'b0;
    bus.m_rdata = 8'($urandom);
    w = modelPick(rq);
    @(negedge pclk);
    if (w < 0) begin
      checkOutput("idle_gnt", 32'(bus.gnt), 32'h0);
      checkOutput("idle_transfer", 32'(bus.transfer), 32'h0);
      checkOutput("idle_done", 32'(bus.done), 32'h0);
      return;
    end
    e_wr    = wr[w];
    e_addr  = ad[w*8 +: 8];
    e_wdata = wd[w*8 +: 8];
    checkOutput("gnt", 32'(bus.gnt), 32'(1 << w));
    checkOutput("transfer", 32'(bus.transfer), 32'h1);
    checkOutput("pwrite_in", 32'(bus.pwrite_in), 32'(e_wr));
    checkOutput("paddr_in", 32'(bus.paddr_in), 32'(e_addr));
    checkOutput("pwdata_in", 32'(bus.pwdata_in), 32'(e_wdata));
    if (abuse) applyStimulus(4'h0, ~wr, {4{8'h7F}}, ~wd);
    to = (dly >= TIMEOUT);
    for (int k = 0; k < TIMEOUT; k++) begin
      bus.m_done  = (k == dly);
      bus.m_rdata = (k == dly) ? mrd : 8'($urandom);
      @(negedge pclk);
      if (k == dly || k == TIMEOUT - 1) break;
      checkOutput("xfer_transfer", 32'(bus.transfer), 32'h1);
      checkOutput("xfer_paddr", 32'(bus.paddr_in), 32'(e_addr));
      checkOutput("xfer_done", 32'(bus.done), 32'h0);
    end
    exp_err   = to;
    exp_rdata = (to || e_wr) ? 8'h00 : mrd;
    ptr_m     = w;
    checkOutput("resp_done", 32'(bus.done), 32'(1 << w));
    checkOutput("resp_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("resp_transfer", 32'(bus.transfer), 32'h0);
    checkOutput("resp_err", 32'(bus.err), 32'(exp_err));
    checkOutput("resp_rdata", 32'(bus.rdata), 32'(exp_rdata));
    // A stray completion outside XFER must be ignored.
    bus.m_done  = 1'b1;
    bus.m_rdata = 8'hEE;
    @(negedge pclk);
    bus.m_done = 1'b0;
    checkOutput("post_done", 32'(bus.done), 32'h0);
    checkOutput("post_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("hold_rdata", 32'(bus.rdata), 32'(exp_rdata));
    checkOutput("hold_err", 32'(bus.err), 32'(exp_err));
  endtask

  initial begin
    int w;
    presetn     = 1'b0;
    bus.m_done  = 1'b0;
    bus.m_rdata = '0;
    applyStimulus(4'hF, 4'h0, 32'h0, 32'h0);
    ptr_m     = NUM_REQ - 1;
    exp_rdata = 8'h00;
    exp_err   = 1'b0;

    // Reset with every requester asking: outputs stay cleared.
    @(negedge pclk);
    checkOutput("rst_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("rst_transfer", 32'(bus.transfer), 32'h0);
    checkOutput("rst_done", 32'(bus.done), 32'h0);
    checkOutput("rst_rdata", 32'(bus.rdata), 32'h0);
    checkOutput("rst_err", 32'(bus.err), 32'h0);
    checkOutput("rst_cmd", {15'h0, bus.pwrite_in, bus.paddr_in, bus.pwdata_in}, 32'h0);
    presetn = 1'b1;
    runTxn(4'hF, 4'h0, 32'h44332211, 32'h0, 1, 8'h3C, 1'b0);

    // Single write from requester 0, single read from requester 2.
    runTxn(4'b0001, 4'b0001, 32'h00000005, 32'h000000AA, 1, 8'h55, 1'b0);
    runTxn(4'b0100, 4'b0000, 32'h00050000, 32'h0, 1, 8'hAA, 1'b0);

    // Held request set is served in strict rotation.
    for (int n = 0; n < 6; n++) begin
      runTxn(4'b1011, 4'b0000, 32'h40302010, 32'h0, 0, 8'(8'h10 + n), 1'b0);
    end

    // Watchdog abort, then normal service, then completion on the watchdog's last cycle.
    runTxn(4'b0010, 4'b0000, 32'h00001200, 32'h0, TIMEOUT + 5, 8'hFF, 1'b0);
    runTxn(4'b0010, 4'b0000, 32'h00001300, 32'h0, 2, 8'h77, 1'b0);
    runTxn(4'b1000, 4'b0000, 32'h14000000, 32'h0, TIMEOUT - 1, 8'h99, 1'b0);

    // Requester inputs scrambled and dropped during XFER.
    runTxn(4'b0001, 4'b0001, 32'h00000021, 32'h000000C3, 3, 8'h00, 1'b1);

    // Reset mid-transfer drops the transaction without a done pulse.
    applyStimulus(4'b0100, 4'b0100, 32'h00330000, 32'h00660000);
    w = modelPick(4'b0100);
    @(negedge pclk);
    checkOutput("mr_gnt", 32'(bus.gnt), 32'(1 << w));
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    checkOutput("mr_transfer", 32'(bus.transfer), 32'h0);
    checkOutput("mr_gnt_clr", 32'(bus.gnt), 32'h0);
    checkOutput("mr_paddr", 32'(bus.paddr_in), 32'h0);
    @(negedge pclk);
    checkOutput("mr_done", 32'(bus.done), 32'h0);
    presetn   = 1'b1;
    bus.req   = 4'h0;
    ptr_m     = NUM_REQ - 1;
    exp_rdata = 8'h00;
    exp_err   = 1'b0;
    @(negedge pclk);
    checkOutput("mr_done_after", 32'(bus.done), 32'h0);
    checkOutput("mr_rdata", 32'(bus.rdata), 32'h0);
    runTxn(4'hF, 4'h0, 32'h0, 32'h0, 0, 8'h5A, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      runTxn(4'($urandom), 4'($urandom), $urandom, $urandom,
             int'($urandom_range(0, TIMEOUT + 2)), 8'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
